cpu_spi_slave: RTL and testbench



---
 rtl/cpu_spi_slave.sv | 198 +++++++++++++++++++
 tb/tb_cpu_spi_slave.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_spi_slave.sv
// cpu_spi_slave: SPI slave (CPOL=0, CPHA=0, MSB first) exposed to the CPU as an Avalon-style register port.
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   SCLK, SS_n, MOSI             SPI inputs from the external master, oversampled in the clk domain
//   MISO, MISO_oe                serial data out and its tristate enable
//   spi_select, mem_addr,
//   read_n, write_n,
//   data_from_cpu, data_to_cpu   register bus (0 rx, 1 tx, 2 status, 3 control)
//   irq                          status flags masked by control enables
//   dataavailable, readyfordata  RRDY and TRDY
module cpu_spi_slave #(
    parameter int DATABITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                SCLK,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic                MISO_oe,
    input  logic                spi_select,
    input  logic [2:0]          mem_addr,
    input  logic                read_n,
    input  logic                write_n,
    input  logic [DATABITS-1:0] data_from_cpu,
    output logic [DATABITS-1:0] data_to_cpu,
    output logic                irq,
    output logic                dataavailable,
    output logic                readyfordata
);
    localparam int CW = $clog2(DATABITS + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [SYNC_STAGES:0]   sclk_q, sclk_d, ss_q, ss_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic [CW-1:0]          bitcnt_q, bitcnt_d;
    logic [DATABITS-1:0]    shift_tx_q, shift_tx_d, shift_rx_q, shift_rx_d;
    logic [DATABITS-1:0]    rx_hold_q, rx_hold_d, tx_hold_q, tx_hold_d;
    logic [DATABITS-1:0]    data_to_cpu_q, data_to_cpu_d;
    logic                   tx_primed_q, tx_primed_d;
    logic                   rrdy_q, rrdy_d, toe_q, toe_d, roe_q, roe_d, tur_q, tur_d;
    logic [8:2]             ctrl_q, ctrl_d;
    logic                   rd_q, rd_d, wr_q, wr_d, irq_q, irq_d;
    logic                   sclk_rise, sclk_fall, ss_s, ss_fall, mosi_s;
    logic                   rd_act, wr_act, load, done;
    logic [8:0]             status;

    // Edges come from the last two synchronized samples, giving SYNC_STAGES+1 clk pin-to-action latency.
    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
    assign ss_s      = ss_q[SYNC_STAGES-1];
    assign ss_fall   = ~ss_q[SYNC_STAGES-1] & ss_q[SYNC_STAGES];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];

    // Bus strobes act only on their first cycle.
    assign rd_d   = spi_select & ~read_n;
    assign wr_d   = spi_select & ~write_n;
    assign rd_act = rd_d & ~rd_q;
    assign wr_act = wr_d & ~wr_q;

    assign status = {toe_q | roe_q | tur_q, rrdy_q, ~tx_primed_q, ss_s & ~tx_primed_q,
                     toe_q, roe_q, tur_q, 2'b00};

    always_comb begin
        sclk_d        = {sclk_q[SYNC_STAGES-1:0], SCLK};
        ss_d          = {ss_q[SYNC_STAGES-1:0], SS_n};
        mosi_d        = {mosi_q[SYNC_STAGES-2:0], MOSI};
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        shift_tx_d    = shift_tx_q;
        shift_rx_d    = shift_rx_q;
        rx_hold_d     = rx_hold_q;
        tx_hold_d     = tx_hold_q;
        tx_primed_d   = tx_primed_q;
        rrdy_d        = rrdy_q;
        toe_d         = toe_q;
        roe_d         = roe_q;
        tur_d         = tur_q;
        ctrl_d        = ctrl_q;
        load          = 1'b0;
        done          = 1'b0;
        // Clears are applied first so that a flag set in the same cycle wins.
        if (wr_act && mem_addr == 3'd2) begin
            rrdy_d = 1'b0;
            toe_d  = 1'b0;
            roe_d  = 1'b0;
            tur_d  = 1'b0;
        end
        if (rd_act && mem_addr == 3'd0)
            rrdy_d = 1'b0;
        if (wr_act && mem_addr == 3'd3)
            ctrl_d = data_from_cpu[8:2];
        if (ss_s) begin
            state_d  = IDLE;
            bitcnt_d = '0;
        end else if (state_q == IDLE) begin
            if (ss_fall) begin
                state_d = SHIFT;
                load    = 1'b1;
            end
        end else begin
            if (sclk_rise) begin
                shift_rx_d = {shift_rx_q[DATABITS-2:0], mosi_s};
                if (bitcnt_q == CW'(DATABITS - 1)) begin
                    done     = 1'b1;
                    bitcnt_d = '0;
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            // A fall with bitcnt at 0 follows a completed word: reload for a back-to-back frame.
            if (sclk_fall) begin
                if (bitcnt_q == '0)
                    load = 1'b1;
                else
                    shift_tx_d = {shift_tx_q[DATABITS-2:0], 1'b0};
            end
        end
        if (done) begin
            rx_hold_d = {shift_rx_q[DATABITS-2:0], mosi_s};
            rrdy_d    = 1'b1;
            if (rrdy_q && !(rd_act && mem_addr == 3'd0))
                roe_d = 1'b1;
        end
        if (load) begin
            shift_tx_d  = tx_primed_q ? tx_hold_q : '0;
            tur_d       = tur_q | ~tx_primed_q;
            tx_primed_d = 1'b0;
        end
        // TRDY is judged on the registered primed bit, so a write racing an unprimed LOAD still lands.
        if (wr_act && mem_addr == 3'd1) begin
            if (!tx_primed_q) begin
                tx_hold_d   = data_from_cpu;
                tx_primed_d = 1'b1;
            end else begin
                toe_d = 1'b1;
            end
        end
        data_to_cpu_d = mem_addr == 3'd0 ? rx_hold_q :
                        mem_addr == 3'd2 ? DATABITS'(status) :
                        mem_addr == 3'd3 ? DATABITS'({ctrl_q, 2'b00}) : '0;
        irq_d         = |(status[8:2] & ctrl_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q        <= '0;
            ss_q          <= '1;
            mosi_q        <= '0;
            state_q       <= IDLE;
            bitcnt_q      <= '0;
            shift_tx_q    <= '0;
            shift_rx_q    <= '0;
            rx_hold_q     <= '0;
            tx_hold_q     <= '0;
            tx_primed_q   <= 1'b0;
            rrdy_q        <= 1'b0;
            toe_q         <= 1'b0;
            roe_q         <= 1'b0;
            tur_q         <= 1'b0;
            ctrl_q        <= '0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            data_to_cpu_q <= '0;
            irq_q         <= 1'b0;
        end else begin
            sclk_q        <= sclk_d;
            ss_q          <= ss_d;
            mosi_q        <= mosi_d;
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            shift_tx_q    <= shift_tx_d;
            shift_rx_q    <= shift_rx_d;
            rx_hold_q     <= rx_hold_d;
            tx_hold_q     <= tx_hold_d;
            tx_primed_q   <= tx_primed_d;
            rrdy_q        <= rrdy_d;
            toe_q         <= toe_d;
            roe_q         <= roe_d;
            tur_q         <= tur_d;
            ctrl_q        <= ctrl_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            data_to_cpu_q <= data_to_cpu_d;
            irq_q         <= irq_d;
        end
    end

    assign MISO          = ~ss_s & (state_q == SHIFT) & shift_tx_q[DATABITS-1];
    assign MISO_oe       = ~ss_s;
    assign data_to_cpu   = data_to_cpu_q;
    assign irq           = irq_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = ~tx_primed_q;
endmodule

// File: tb/tb_cpu_spi_slave.sv
// tb_cpu_spi_slave: directed bench for cpu_spi_slave acting as an external SPI master and CPU.
module tb_cpu_spi_slave;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        SCLK = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO, MISO_oe;
    logic        spi_select = 1'b0;
    logic [2:0]  mem_addr = 3'd0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [15:0] data_from_cpu = 16'h0;
    logic [15:0] data_to_cpu;
    logic        irq, dataavailable, readyfordata;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mi, rd;

    cpu_spi_slave dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
        .readyfordata(readyfordata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        spi_select = 1'b1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
        @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
        @(negedge clk);
        d = data_to_cpu;
        spi_select = 1'b0; read_n = 1'b1;
        @(negedge clk);
    endtask

    // Shifts nbits MSB-first at clk/10; MISO is sampled at each SCLK rise.
    // With rel set, the final SCLK fall coincides with SS_n release so no reload happens.
    task automatic xfer(input logic [15:0] mo, input int nbits, input bit rel, output logic [15:0] mo_in);
        mo_in = '0;
        for (int k = 0; k < nbits; k++) begin
            MOSI = mo[15-k];
            repeat (5) @(negedge clk);
            SCLK = 1'b1;
            mo_in[15-k] = MISO;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
            if (rel && k == nbits - 1)
                SS_n = 1'b1;
        end
    endtask

    task automatic frame(input logic [15:0] mo, output logic [15:0] mo_in);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        xfer(mo, 16, 1'b1, mo_in);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_miso", MISO, 0);
        chk("reset_miso_oe", MISO_oe, 0);
        chk("reset_data_to_cpu", data_to_cpu, 0);
        chk("reset_irq", irq, 0);
        chk("reset_rrdy", dataavailable, 0);
        chk("reset_trdy", readyfordata, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(3'd2, rd); chk("reset_status", rd, 16'h0060);

        // Basic frame: tx 0xA5C3 out, 0x1234 in
        bus_write(3'd1, 16'hA5C3);
        chk("t1_trdy_primed", readyfordata, 0);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("t1_miso_oe", MISO_oe, 1);
        xfer(16'h1234, 16, 1'b1, mi);
        repeat (4) @(negedge clk);
        chk("t1_miso_word", mi, 16'hA5C3);
        chk("t1_rrdy", dataavailable, 1);
        chk("t1_trdy", readyfordata, 1);
        chk("t1_miso_oe_off", MISO_oe, 0);
        bus_read(3'd2, rd); chk("t1_status", rd, 16'h00E0);
        bus_read(3'd0, rd); chk("t1_rx", rd, 16'h1234);
        chk("t1_rrdy_cleared", dataavailable, 0);

        // Back-to-back frames under one SS_n
        bus_write(3'd1, 16'h0001);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        bus_write(3'd1, 16'h8000);
        xfer(16'h1111, 16, 1'b0, mi);
        chk("t2_miso_f1", mi, 16'h0001);
        repeat (3) @(negedge clk);
        bus_read(3'd0, rd); chk("t2_rx_f1", rd, 16'h1111);
        bus_read(3'd2, rd); chk("t2_status_mid", rd, 16'h0040);
        xfer(16'h2222, 16, 1'b0, mi);
        chk("t2_miso_f2", mi, 16'h8000);
        repeat (3) @(negedge clk);
        bus_read(3'd0, rd); chk("t2_rx_f2", rd, 16'h2222);
        xfer(16'h3333, 16, 1'b1, mi);
        repeat (4) @(negedge clk);
        chk("t2_miso_f3", mi, 16'h0000);
        bus_read(3'd2, rd); chk("t2_status_tur", rd, 16'h01E4);
        bus_read(3'd0, rd); chk("t2_rx_f3", rd, 16'h3333);
        bus_write(3'd2, 16'h0000);
        bus_read(3'd2, rd); chk("t2_status_clr", rd, 16'h0060);

        // Overrun and interrupt
        frame(16'h1357, mi);
        frame(16'h2468, mi);
        bus_read(3'd2, rd); chk("t3_status_roe", rd, 16'h01EC);
        chk("t3_irq_masked", irq, 0);
        bus_write(3'd3, 16'h0008);
        @(negedge clk);
        chk("t3_irq_on", irq, 1);
        bus_read(3'd3, rd); chk("t3_ctrl", rd, 16'h0008);
        bus_read(3'd0, rd); chk("t3_rx", rd, 16'h2468);
        bus_write(3'd2, 16'h0000);
        @(negedge clk);
        chk("t3_irq_off", irq, 0);
        bus_read(3'd2, rd); chk("t3_status_clr", rd, 16'h0060);
        bus_write(3'd3, 16'h0000);

        // Tx overrun keeps the first word
        bus_write(3'd1, 16'h1111);
        bus_write(3'd1, 16'h2222);
        bus_read(3'd2, rd); chk("t4_status_toe", rd, 16'h0110);
        frame(16'h0000, mi);
        chk("t4_miso_word", mi, 16'h1111);
        bus_read(3'd2, rd); chk("t4_status_after", rd, 16'h01F0);
        bus_write(3'd2, 16'h0000);

        // Aborted frame after 7 bits
        bus_write(3'd1, 16'h0F0F);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        xfer(16'hA000, 7, 1'b1, mi);
        repeat (6) @(negedge clk);
        chk("t5_rrdy_abort", dataavailable, 0);
        bus_read(3'd2, rd); chk("t5_status_abort", rd, 16'h0060);
        bus_write(3'd1, 16'hCAFE);
        frame(16'hBEEF, mi);
        chk("t5_miso_word", mi, 16'hCAFE);
        bus_read(3'd0, rd); chk("t5_rx", rd, 16'hBEEF);

        // Reset mid-frame
        bus_write(3'd1, 16'h5555);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        xfer(16'hFFFF, 5, 1'b0, mi);
        reset_n = 1'b0;
        SS_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_miso", MISO, 0);
        chk("t6_miso_oe", MISO_oe, 0);
        chk("t6_data_to_cpu", data_to_cpu, 0);
        chk("t6_irq", irq, 0);
        chk("t6_rrdy", dataavailable, 0);
        chk("t6_trdy", readyfordata, 1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(3'd2, rd); chk("t6_status", rd, 16'h0060);
        bus_write(3'd1, 16'h6789);
        frame(16'h4321, mi);
        chk("t6_miso_word", mi, 16'h6789);
        bus_read(3'd0, rd); chk("t6_rx", rd, 16'h4321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
